fwd_hazard_ctrl: RTL and testbench

//   Generates the 2-bit operand-select codes consumed by the EX-stage 4:1 operand muxes (MUX32_Double).

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/fwd_sel_logic.sv | 25 ++
 rtl/fwd_hazard_ctrl.sv | 96 +++++++++
 tb/tb_fwd_hazard_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: operand-select encoding and the shadow record
// carried down ID/EX, EX/MEM and MEM/WB for hazard tracking.
package pipe_pkg;

  localparam int RA_W = 5;

  // Operand-mux select codes; 2'b11 is reserved and never driven.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } shadow_t;

endpackage

// File: rtl/fwd_sel_logic.sv
// Priority compare for one EX operand: the newest producer (EX/MEM) wins over
// MEM/WB; x0 is never a forwarding source.
module fwd_sel_logic #(
  parameter int RA_W  = 5,
  parameter int SEL_W = 2
) (
  input  logic [RA_W-1:0]  rs_i,
  input  logic [RA_W-1:0]  exmem_rd_i,
  input  logic             exmem_we_i,
  input  logic [RA_W-1:0]  memwb_rd_i,
  input  logic             memwb_we_i,
  output logic [SEL_W-1:0] sel_o
);
  import pipe_pkg::*;

  // Pick the youngest in-flight writer of rs, else the register file.
  always_comb begin
    sel_o = SEL_W'(FWD_RF);
    if (exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i))
      sel_o = SEL_W'(FWD_EXMEM);
    else if (memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i))
      sel_o = SEL_W'(FWD_MEMWB);
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control for the 5-stage pipeline.
// Tracks a shadow copy of register usage per stage; forwarding selects come
// straight from flops, the stall is combinational against the ID inputs.
// RA_W must match pipe_pkg::RA_W, which sizes the shadow record.
module fwd_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [RA_W-1:0]  id_rs1_i,
  input  logic [RA_W-1:0]  id_rs2_i,
  input  logic [RA_W-1:0]  id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [SEL_W-1:0] fwd_a_o,
  output logic [SEL_W-1:0] fwd_b_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  import pipe_pkg::*;

  shadow_t          idex_q, idex_d;
  shadow_t          exmem_q, exmem_d;
  shadow_t          memwb_q, memwb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  // Load-use hazard: a load in EX whose rd feeds the instruction in ID.
  // A taken branch squashes the ID instruction, so it never stalls.
  always_comb begin
    stall = id_valid_i && !flush_i && idex_q.memread && (idex_q.rd != '0)
            && ((idex_q.rd == id_rs1_i) || (idex_q.rd == id_rs2_i));
  end

  // Shadow pipeline advance; stall, flush or an empty ID slot inject a bubble.
  always_comb begin
    exmem_d = idex_q;
    memwb_d = exmem_q;
    idex_d  = '0;
    if (!(stall || flush_i || !id_valid_i)) begin
      idex_d.rs1      = id_rs1_i;
      idex_d.rs2      = id_rs2_i;
      idex_d.rd       = id_rd_i;
      idex_d.regwrite = id_regwrite_i;
      idex_d.memread  = id_memread_i;
    end
  end

  // Saturating stall-cycle counter for CPI measurement.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers; reset drops any in-progress stall along with the shadows.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      cnt_q   <= cnt_d;
    end
  end

  fwd_sel_logic #(.RA_W(RA_W), .SEL_W(SEL_W)) u_fwd_a (
    .rs_i       (idex_q.rs1),
    .exmem_rd_i (exmem_q.rd),
    .exmem_we_i (exmem_q.regwrite),
    .memwb_rd_i (memwb_q.rd),
    .memwb_we_i (memwb_q.regwrite),
    .sel_o      (fwd_a_o)
  );

  fwd_sel_logic #(.RA_W(RA_W), .SEL_W(SEL_W)) u_fwd_b (
    .rs_i       (idex_q.rs2),
    .exmem_rd_i (exmem_q.rd),
    .exmem_we_i (exmem_q.regwrite),
    .memwb_rd_i (memwb_q.rd),
    .memwb_we_i (memwb_q.regwrite),
    .sel_o      (fwd_b_o)
  );

  assign stall_o     = stall;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl. Two instances share stimulus: the
// default-width counter and a 2-bit counter to observe saturation.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_regwrite, id_memread, flush;

  logic [1:0]  fwd_a, fwd_b, sat_fwd_a, sat_fwd_b;
  logic        stall, sat_stall;
  logic [15:0] stall_cnt;
  logic [1:0]  sat_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [1:0] a;
    logic [1:0] b;
    logic       st;
    int         cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fwd_hazard_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .flush_i(flush),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_o(stall), .stall_cnt_o(stall_cnt)
  );

  fwd_hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .flush_i(flush),
    .fwd_a_o(sat_fwd_a), .fwd_b_o(sat_fwd_b), .stall_o(sat_stall), .stall_cnt_o(sat_cnt)
  );

  // One cycle: drive ID, queue the expectation, check mid-cycle, advance.
  task automatic cyc(input logic r, input logic v, input int rs1, input int rs2,
                     input int rd, input logic we, input logic mr, input logic fl,
                     input string tag, input logic [1:0] ea, input logic [1:0] eb,
                     input logic es, input int ecnt);
    exp_t e;
    logic [15:0] ec16;
    logic [1:0]  ec2;
    rst = r; id_valid = v;
    id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_regwrite = we; id_memread = mr; flush = fl;
    sb.push_back('{tag, ea, eb, es, ecnt});
    @(negedge clk);
    e = sb.pop_front();
    ec16 = 16'(e.cnt);
    ec2  = (e.cnt > 3) ? 2'd3 : 2'(e.cnt);
    tests++;
    assert (fwd_a === e.a) else begin fails++;
      $error("FAIL %s fwd_a got %b exp %b", e.tag, fwd_a, e.a); end
    tests++;
    assert (fwd_b === e.b) else begin fails++;
      $error("FAIL %s fwd_b got %b exp %b", e.tag, fwd_b, e.b); end
    tests++;
    assert (stall === e.st) else begin fails++;
      $error("FAIL %s stall got %b exp %b", e.tag, stall, e.st); end
    tests++;
    assert (stall_cnt === ec16) else begin fails++;
      $error("FAIL %s stall_cnt got %0d exp %0d", e.tag, stall_cnt, ec16); end
    tests++;
    assert (sat_cnt === ec2) else begin fails++;
      $error("FAIL %s sat_cnt got %0d exp %0d", e.tag, sat_cnt, ec2); end
    tests++;
    assert ({sat_fwd_a, sat_fwd_b, sat_stall} === {e.a, e.b, e.st}) else begin fails++;
      $error("FAIL %s sat_outs got %b exp %b", e.tag,
             {sat_fwd_a, sat_fwd_b, sat_stall}, {e.a, e.b, e.st}); end
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input string tag, input logic [1:0] ea, input logic [1:0] eb, input int ecnt);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, tag, ea, eb, 1'b0, ecnt);
  endtask

  initial begin
    rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_regwrite = 0; id_memread = 0; flush = 0;
    @(posedge clk); @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset", 2'b00, 2'b00, 0, 0);

    // EX hazard: add x5 <- x1+x2 ; sub x6 <- x5-x3
    cyc(0, 1, 1, 2, 5, 1, 0, 0, "ex_add",  2'b00, 2'b00, 0, 0);
    cyc(0, 1, 5, 3, 6, 1, 0, 0, "ex_sub",  2'b00, 2'b00, 0, 0);
    nop("ex_fwd", 2'b10, 2'b00, 0);

    // MEM hazard: add x5 ; nop ; or x7 <- x4|x5
    cyc(0, 1, 1, 2, 5, 1, 0, 0, "mem_add", 2'b00, 2'b00, 0, 0);
    nop("mem_nop", 2'b00, 2'b00, 0);
    cyc(0, 1, 4, 5, 7, 1, 0, 0, "mem_or",  2'b00, 2'b00, 0, 0);
    nop("mem_fwd", 2'b00, 2'b01, 0);

    // Double hazard: add x5 ; add x5 ; and x8 <- x5&x5
    cyc(0, 1, 1, 2, 5, 1, 0, 0, "dbl_add1", 2'b00, 2'b00, 0, 0);
    cyc(0, 1, 1, 2, 5, 1, 0, 0, "dbl_add2", 2'b00, 2'b00, 0, 0);
    cyc(0, 1, 5, 5, 8, 1, 0, 0, "dbl_and",  2'b00, 2'b00, 0, 0);
    nop("dbl_fwd", 2'b10, 2'b10, 0);

    // Load-use on rs1: lw x9 ; add x10 <- x9+x1 (held one cycle)
    cyc(0, 1, 1, 0, 9, 1, 1, 0, "lu_lw",    2'b00, 2'b00, 0, 0);
    cyc(0, 1, 9, 1, 10, 1, 0, 0, "lu_stall", 2'b00, 2'b00, 1, 0);
    cyc(0, 1, 9, 1, 10, 1, 0, 0, "lu_held",  2'b00, 2'b00, 0, 1);
    nop("lu_fwd", 2'b01, 2'b00, 1);

    // x0 is never forwarded
    cyc(0, 1, 1, 2, 0, 1, 0, 0, "x0_add", 2'b00, 2'b00, 0, 1);
    cyc(0, 1, 0, 0, 11, 1, 0, 0, "x0_use", 2'b00, 2'b00, 0, 1);
    nop("x0_fwd", 2'b00, 2'b00, 1);

    // Flush beats a load-use hazard
    cyc(0, 1, 1, 0, 9, 1, 1, 0, "fl_lw",    2'b00, 2'b00, 0, 1);
    cyc(0, 1, 9, 1, 10, 1, 0, 1, "fl_flush", 2'b00, 2'b00, 0, 1);
    nop("fl_after", 2'b00, 2'b00, 1);

    // Load-use on rs2
    cyc(0, 1, 2, 0, 9, 1, 1, 0, "lu2_lw",    2'b00, 2'b00, 0, 1);
    cyc(0, 1, 1, 9, 12, 1, 0, 0, "lu2_stall", 2'b00, 2'b00, 1, 1);
    cyc(0, 1, 1, 9, 12, 1, 0, 0, "lu2_held",  2'b00, 2'b00, 0, 2);
    nop("lu2_fwd", 2'b00, 2'b01, 2);

    // Reset during a load-use stall
    cyc(0, 1, 1, 0, 9, 1, 1, 0, "rs_lw",    2'b00, 2'b00, 0, 2);
    cyc(1, 1, 9, 1, 10, 1, 0, 0, "rs_stall", 2'b00, 2'b00, 1, 2);
    nop("rs_clean", 2'b00, 2'b00, 0);

    // Back-to-back dependent loads: lw x9 <- (x9) stalls every other cycle
    for (int j = 0; j < 10; j++) begin
      cyc(0, 1, 9, 0, 9, 1, 1, 0, $sformatf("sat_%0d", j),
          (j % 2 == 1 && j != 1) ? 2'b01 : 2'b00, 2'b00, 1'(j % 2), j / 2);
    end
    nop("sat_end", 2'b00, 2'b00, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
